// File: rtl/startup_sequencer_if.sv
// Signal bundle between the startup sequencer and the Virtex-4 startup primitive.
// The sequencer drives the primitive's control inputs and receives its EOS output.
interface startup_sequencer_if;
  logic gsr;
  logic gts;
  logic usrdoneo;
  logic usrdonets;
  logic usrcclko;
  logic usrcclkts;
  logic eos;

  modport master (
    output gsr, gts, usrdoneo, usrdonets, usrcclko, usrcclkts,
    input  eos
  );

  modport slave (
    input  gsr, gts, usrdoneo, usrdonets, usrcclko, usrcclkts,
    output eos
  );
endinterface

// File: rtl/startup_sequencer.sv
// Power-up sequencer: releases GSR, then GTS, waits for EOS, then drives user DONE
// and an optional divided user CCLK. All outputs are registered from the next state.
module startup_sequencer #(
  parameter int unsigned GSR_CYCLES  = 16,
  parameter int unsigned GTS_DELAY   = 8,
  parameter int unsigned DONE_DELAY  = 4,
  parameter int unsigned EOS_TIMEOUT = 1024,
  parameter int unsigned CCLK_DIV    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                cclk_en,
  startup_sequencer_if.master prim,
  output logic                ready,
  output logic                error,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ASSERT_GSR  = 3'd1,
    RELEASE_GTS = 3'd2,
    WAIT_EOS    = 3'd3,
    DONE_DLY    = 3'd4,
    RUN         = 3'd5,
    FAULT       = 3'd6
  } state_t;

  localparam logic [15:0] GSR_LOAD  = 16'(GSR_CYCLES - 1);
  localparam logic [15:0] GTS_LOAD  = 16'(GTS_DELAY - 1);
  localparam logic [15:0] DONE_LOAD = 16'(DONE_DELAY - 1);
  localparam logic [15:0] EOS_LOAD  = 16'(EOS_TIMEOUT - 1);
  localparam logic [7:0]  CCLK_LAST = 8'(CCLK_DIV - 1);

  state_t      state_q, state_n;
  logic [15:0] cnt_q, cnt_n;
  logic [7:0]  div_q, div_n;
  logic        eos_meta, eos_sync;

  logic gsr_q, gsr_n;
  logic gts_q, gts_n;
  logic done_q, done_n;
  logic done_ts_q, done_ts_n;
  logic cclk_q, cclk_n;
  logic cclk_ts_q, cclk_ts_n;
  logic ready_q, ready_n;
  logic error_q, error_n;

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;

    case (state_q)
      IDLE, FAULT: begin
        if (start) begin
          state_n = ASSERT_GSR;
          cnt_n   = GSR_LOAD;
        end
      end
      ASSERT_GSR: begin
        if (cnt_q == 16'd0) begin
          state_n = RELEASE_GTS;
          cnt_n   = GTS_LOAD;
        end else begin
          cnt_n = cnt_q - 16'd1;
        end
      end
      RELEASE_GTS: begin
        if (cnt_q == 16'd0) begin
          state_n = WAIT_EOS;
          cnt_n   = EOS_LOAD;
        end else begin
          cnt_n = cnt_q - 16'd1;
        end
      end
      WAIT_EOS: begin
        // EOS takes priority over an expiring timeout on the same cycle.
        if (eos_sync) begin
          state_n = DONE_DLY;
          cnt_n   = DONE_LOAD;
        end else if (cnt_q == 16'd0) begin
          state_n = FAULT;
        end else begin
          cnt_n = cnt_q - 16'd1;
        end
      end
      DONE_DLY: begin
        if (!eos_sync) begin
          state_n = FAULT;
        end else if (cnt_q == 16'd0) begin
          state_n = RUN;
        end else begin
          cnt_n = cnt_q - 16'd1;
        end
      end
      RUN: begin
        if (!eos_sync) state_n = FAULT;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 16'd0;
      end
    endcase

    gsr_n     = 1'b1;
    gts_n     = 1'b1;
    done_n    = 1'b0;
    done_ts_n = 1'b1;
    ready_n   = 1'b0;
    error_n   = 1'b0;

    case (state_n)
      RELEASE_GTS: gsr_n = 1'b0;
      WAIT_EOS, DONE_DLY: begin
        gsr_n = 1'b0;
        gts_n = 1'b0;
      end
      RUN: begin
        gsr_n     = 1'b0;
        gts_n     = 1'b0;
        done_n    = 1'b1;
        done_ts_n = 1'b0;
        ready_n   = 1'b1;
      end
      FAULT: begin
        gsr_n   = gsr_q;
        gts_n   = gts_q;
        error_n = 1'b1;
      end
      default: ;
    endcase

    // The divider only starts counting once the clock is already driven, so the
    // first half-period after enabling is a full CCLK_DIV cycles long.
    cclk_n    = 1'b0;
    cclk_ts_n = 1'b1;
    div_n     = 8'd0;
    if (state_n == RUN && cclk_en) begin
      cclk_ts_n = 1'b0;
      if (!cclk_ts_q) begin
        if (div_q == CCLK_LAST) begin
          cclk_n = ~cclk_q;
          div_n  = 8'd0;
        end else begin
          cclk_n = cclk_q;
          div_n  = div_q + 8'd1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 16'd0;
      div_q     <= 8'd0;
      eos_meta  <= 1'b0;
      eos_sync  <= 1'b0;
      gsr_q     <= 1'b1;
      gts_q     <= 1'b1;
      done_q    <= 1'b0;
      done_ts_q <= 1'b1;
      cclk_q    <= 1'b0;
      cclk_ts_q <= 1'b1;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      div_q     <= div_n;
      eos_meta  <= prim.eos;
      eos_sync  <= eos_meta;
      gsr_q     <= gsr_n;
      gts_q     <= gts_n;
      done_q    <= done_n;
      done_ts_q <= done_ts_n;
      cclk_q    <= cclk_n;
      cclk_ts_q <= cclk_ts_n;
      ready_q   <= ready_n;
      error_q   <= error_n;
    end
  end

  assign prim.gsr       = gsr_q;
  assign prim.gts       = gts_q;
  assign prim.usrdoneo  = done_q;
  assign prim.usrdonets = done_ts_q;
  assign prim.usrcclko  = cclk_q;
  assign prim.usrcclkts = cclk_ts_q;
  assign ready          = ready_q;
  assign error          = error_q;
  assign state          = state_q;

endmodule
